// File: rtl/pwm_cmd_decoder.sv
// SPI command decoder for the PWM stage: validates 16-bit words, holds per-channel
// duty targets, slews live duty toward them and zeroes targets on SPI silence.
module pwm_cmd_decoder #(
   parameter int NCH       = 10,
   parameter int RAMP_DIV  = 50000,
   parameter int WD_CYCLES = 100000000
) (
   input  logic             clk50M,
   input  logic             rst,
   input  logic [15:0]      byte_data_received,
   input  logic             byte_received,
   output logic [8*NCH-1:0] duty_bus,
   output logic [7:0]       step_target,
   output logic             step_valid,
   output logic             wd_timeout,
   output logic [7:0]       err_cnt
);

   localparam int TW = $clog2(RAMP_DIV + 1);
   localparam int WW = $clog2(WD_CYCLES + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);
   localparam logic [WW-1:0] WD_LAST   = WW'(WD_CYCLES - 1);
   localparam logic [4:0]    NCH_L     = 5'(NCH);
   localparam logic [3:0]    ADDR_STEP = 4'hA;
   localparam logic [3:0]    ADDR_OFF  = 4'hB;
   localparam logic [3:0]    ADDR_RAMP = 4'hC;

   logic          byte_received_q;
   logic          word_stb;
   logic [15:0]   word_q;
   logic          ramp_en;
   logic [TW-1:0] tick_cnt;
   logic [WW-1:0] wd_cnt;
   logic [7:0]    target [NCH];
   logic [7:0]    duty   [NCH];

   logic [3:0]    addr;
   logic [7:0]    data;
   logic          chk_ok;
   logic          addr_ok;
   logic          cmd_valid;
   logic          tick;

   assign addr      = word_q[15:12];
   assign data      = word_q[7:0];
   assign chk_ok    = (word_q[11:8] == (addr ^ 4'hA));
   assign addr_ok   = ({1'b0, addr} < NCH_L) || (addr == ADDR_STEP) ||
                      (addr == ADDR_OFF) || (addr == ADDR_RAMP);
   assign cmd_valid = word_stb && chk_ok && addr_ok;
   assign tick      = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         byte_received_q <= 1'b0;
         word_stb        <= 1'b0;
         word_q          <= '0;
         ramp_en         <= 1'b1;
         tick_cnt        <= '0;
         wd_cnt          <= '0;
         wd_timeout      <= 1'b0;
         step_target     <= '0;
         step_valid      <= 1'b0;
         err_cnt         <= '0;
         for (int k = 0; k < NCH; k++) begin
            target[k] <= '0;
            duty[k]   <= '0;
         end
      end else begin
         byte_received_q <= byte_received;
         word_stb        <= byte_received & ~byte_received_q;
         word_q          <= byte_data_received;
         step_valid      <= 1'b0;
         tick_cnt        <= tick ? '0 : tick_cnt + 1'b1;

         // Ramp steps against the target held before this edge; a same-cycle
         // write only takes effect on the following tick.
         for (int k = 0; k < NCH; k++) begin
            if (!ramp_en)
               duty[k] <= target[k];
            else if (tick) begin
               if (duty[k] < target[k])
                  duty[k] <= duty[k] + 8'd1;
               else if (duty[k] > target[k])
                  duty[k] <= duty[k] - 8'd1;
            end
         end

         if (cmd_valid) begin
            wd_cnt     <= '0;
            wd_timeout <= 1'b0;
         end else if (wd_cnt == WD_LAST) begin
            wd_timeout <= 1'b1;
            for (int k = 0; k < NCH; k++)
               target[k] <= '0;
         end else begin
            wd_cnt <= wd_cnt + 1'b1;
         end

         if (word_stb && !cmd_valid && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;

         if (cmd_valid) begin
            for (int k = 0; k < NCH; k++)
               if (addr == 4'(k))
                  target[k] <= data;
            case (addr)
               ADDR_STEP: begin
                  step_target <= data;
                  step_valid  <= 1'b1;
               end
               ADDR_OFF: begin
                  for (int k = 0; k < NCH; k++) begin
                     target[k] <= '0;
                     duty[k]   <= '0;
                  end
               end
               ADDR_RAMP: ramp_en <= data[0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      duty_bus = '0;
      for (int k = 0; k < NCH; k++)
         duty_bus[8*k +: 8] = duty[k];
   end

endmodule

// File: tb/tb_pwm_cmd_decoder.sv
// Directed bench for pwm_cmd_decoder with a fast ramp tick and short watchdog.
module tb_pwm_cmd_decoder;
   localparam int NCH       = 10;
   localparam int RAMP_DIV  = 4;
   localparam int WD_CYCLES = 200;

   logic             clk50M = 1'b0;
   logic             rst;
   logic [15:0]      byte_data_received;
   logic             byte_received;
   logic [8*NCH-1:0] duty_bus;
   logic [7:0]       step_target;
   logic             step_valid;
   logic             wd_timeout;
   logic [7:0]       err_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   pwm_cmd_decoder #(.NCH(NCH), .RAMP_DIV(RAMP_DIV), .WD_CYCLES(WD_CYCLES)) dut (
      .clk50M             (clk50M),
      .rst                (rst),
      .byte_data_received (byte_data_received),
      .byte_received      (byte_received),
      .duty_bus           (duty_bus),
      .step_target        (step_target),
      .step_valid         (step_valid),
      .wd_timeout         (wd_timeout),
      .err_cnt            (err_cnt)
   );

   always #5 clk50M = ~clk50M;

   function automatic logic [7:0] dch(input int k);
      return duty_bus[8*k +: 8];
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk50M);
   endtask

   // Called at a negedge; raises the word for one clock and returns at the next negedge.
   task automatic send_word(input logic [15:0] w);
      byte_data_received = w;
      byte_received      = 1'b1;
      @(negedge clk50M);
      byte_received      = 1'b0;
   endtask

   task automatic reset_dut;
      rst = 1'b1;
      byte_received = 1'b0;
      byte_data_received = '0;
      cycles(2);
      rst = 1'b0;
      cycles(1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      byte_received = 1'b0;
      byte_data_received = '0;
      cycles(2);
      n_tests++; if (duty_bus !== '0) begin n_fail++; $display("FAIL reset_duty got %h want 0", duty_bus); end
      n_tests++; if (step_target !== 8'h00) begin n_fail++; $display("FAIL reset_step got %h want 00", step_target); end
      n_tests++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL reset_step_valid got %b want 0", step_valid); end
      n_tests++; if (wd_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_wd got %b want 0", wd_timeout); end
      n_tests++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_err got %h want 00", err_cnt); end
      rst = 1'b0;
      cycles(1);
   endtask

   task automatic test_ramp;
      logic [7:0] prev, cur;
      int last_change, step_err, n_changes;
      logic others_bad;
      reset_dut();
      prev = 8'h00; last_change = -1; step_err = 0; n_changes = 0; others_bad = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc % 100 == 0) begin
            byte_data_received = 16'h3980;
            byte_received = 1'b1;
         end else if (cyc % 100 == 1) begin
            byte_received = 1'b0;
         end
         @(negedge clk50M);
         cur = dch(3);
         if (cur != prev) begin
            if (cur != prev + 8'd1) step_err++;
            if (last_change >= 0 && cyc - last_change != RAMP_DIV) step_err++;
            last_change = cyc;
            n_changes++;
         end
         prev = cur;
         for (int k = 0; k < NCH; k++)
            if (k != 3 && dch(k) != 8'h00) others_bad = 1'b1;
      end
      n_tests++; if (dch(3) !== 8'h80) begin n_fail++; $display("FAIL ramp_final got %h want 80", dch(3)); end
      n_tests++; if (step_err !== 0) begin n_fail++; $display("FAIL ramp_step_rate got %0d errors want 0", step_err); end
      n_tests++; if (n_changes !== 128) begin n_fail++; $display("FAIL ramp_step_count got %0d want 128", n_changes); end
      n_tests++; if (others_bad !== 1'b0) begin n_fail++; $display("FAIL ramp_other_ch got %b want 0", others_bad); end
      n_tests++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL ramp_err got %h want 00", err_cnt); end
      n_tests++; if (wd_timeout !== 1'b0) begin n_fail++; $display("FAIL ramp_wd got %b want 0", wd_timeout); end
   endtask

   task automatic test_ramp_off;
      reset_dut();
      send_word(16'hC600);
      cycles(1);
      send_word(16'h0AFF);
      cycles(1);
      n_tests++; if (dch(0) !== 8'h00) begin n_fail++; $display("FAIL rampoff_early got %h want 00", dch(0)); end
      cycles(1);
      n_tests++; if (dch(0) !== 8'hFF) begin n_fail++; $display("FAIL rampoff_duty got %h want FF", dch(0)); end
   endtask

   task automatic test_step;
      int pulses;
      reset_dut();
      send_word(16'hA037);
      cycles(1);
      n_tests++; if (step_valid !== 1'b1) begin n_fail++; $display("FAIL step_pulse got %b want 1", step_valid); end
      n_tests++; if (step_target !== 8'h37) begin n_fail++; $display("FAIL step_target got %h want 37", step_target); end
      cycles(1);
      n_tests++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL step_pulse_end got %b want 0", step_valid); end
      pulses = 0;
      byte_data_received = 16'hA042;
      byte_received = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (i == 10) byte_received = 1'b0;
         @(negedge clk50M);
         if (step_valid) pulses++;
      end
      n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL step_held got %0d pulses want 1", pulses); end
      n_tests++; if (step_target !== 8'h42) begin n_fail++; $display("FAIL step_held_target got %h want 42", step_target); end
   endtask

   task automatic test_back_to_back;
      int pulses;
      reset_dut();
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         byte_received = (i == 0 || i == 2);
         byte_data_received = (i < 2) ? 16'hA011 : 16'hA022;
         @(negedge clk50M);
         if (step_valid) pulses++;
      end
      n_tests++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
      n_tests++; if (step_target !== 8'h22) begin n_fail++; $display("FAIL b2b_target got %h want 22", step_target); end
   endtask

   task automatic test_errors;
      reset_dut();
      send_word(16'h3880); cycles(1);
      send_word(16'hD700); cycles(1);
      n_tests++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL err_two got %0d want 2", err_cnt); end
      n_tests++; if (duty_bus !== '0) begin n_fail++; $display("FAIL err_duty got %h want 0", duty_bus); end
      n_tests++; if (step_target !== 8'h00) begin n_fail++; $display("FAIL err_step got %h want 00", step_target); end
      for (int i = 0; i < 252; i++) begin send_word(16'hF000); cycles(1); end
      n_tests++; if (err_cnt !== 8'd254) begin n_fail++; $display("FAIL err_254 got %0d want 254", err_cnt); end
      send_word(16'h3880); cycles(1);
      n_tests++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_255 got %0d want 255", err_cnt); end
      for (int i = 0; i < 5; i++) begin send_word(16'hE400); cycles(1); end
      n_tests++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_sat got %0d want 255", err_cnt); end
   endtask

   task automatic test_watchdog;
      logic stayed_low;
      reset_dut();
      send_word(16'hC600); cycles(1);
      send_word(16'h5F10);
      cycles(200);
      n_tests++; if (wd_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early got %b want 0", wd_timeout); end
      n_tests++; if (dch(5) !== 8'h10) begin n_fail++; $display("FAIL wd_duty_before got %h want 10", dch(5)); end
      cycles(1);
      n_tests++; if (wd_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_trip got %b want 1", wd_timeout); end
      cycles(1);
      n_tests++; if (dch(5) !== 8'h00) begin n_fail++; $display("FAIL wd_duty_zero got %h want 00", dch(5)); end
      send_word(16'h5F20);
      cycles(1);
      n_tests++; if (wd_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_clear got %b want 0", wd_timeout); end
      cycles(1);
      n_tests++; if (dch(5) !== 8'h20) begin n_fail++; $display("FAIL wd_recover got %h want 20", dch(5)); end
      cycles(197);
      send_word(16'h5F30);
      stayed_low = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk50M);
         if (wd_timeout) stayed_low = 1'b0;
      end
      n_tests++; if (stayed_low !== 1'b1) begin n_fail++; $display("FAIL wd_cmd_wins got %b want 1", stayed_low); end
      n_tests++; if (dch(5) !== 8'h30) begin n_fail++; $display("FAIL wd_cmd_wins_duty got %h want 30", dch(5)); end
   endtask

   task automatic test_all_off_and_reset;
      int d;
      reset_dut();
      send_word(16'h28FF);
      cycles(40);
      d = int'(dch(2));
      n_tests++; if (d < 8 || d > 12) begin n_fail++; $display("FAIL alloff_midramp got %0d want 8..12", d); end
      send_word(16'hB100);
      cycles(1);
      n_tests++; if (duty_bus !== '0) begin n_fail++; $display("FAIL alloff_now got %h want 0", duty_bus); end
      cycles(10);
      n_tests++; if (duty_bus !== '0) begin n_fail++; $display("FAIL alloff_hold got %h want 0", duty_bus); end

      send_word(16'h28FF); cycles(1);
      send_word(16'hA055); cycles(1);
      send_word(16'h2700); cycles(30);
      n_tests++; if (step_target !== 8'h55 || err_cnt !== 8'd1 || dch(2) == 8'h00)
         begin n_fail++; $display("FAIL prereset_state got st=%h err=%0d d2=%h want 55/1/nonzero", step_target, err_cnt, dch(2)); end
      #2;
      rst = 1'b1;
      #1;
      n_tests++; if (duty_bus !== '0 || step_target !== 8'h00 || err_cnt !== 8'h00 || step_valid !== 1'b0 || wd_timeout !== 1'b0)
         begin n_fail++; $display("FAIL async_reset got duty=%h st=%h err=%h sv=%b wd=%b want all 0", duty_bus, step_target, err_cnt, step_valid, wd_timeout); end
      cycles(2);
      rst = 1'b0;
      cycles(1);
      send_word(16'h1BFF);
      cycles(21);
      d = int'(dch(1));
      n_tests++; if (d < 3 || d > 6) begin n_fail++; $display("FAIL ramp_after_reset got %0d want 3..6", d); end
   endtask

   initial begin
      rst = 1'b1;
      byte_received = 1'b0;
      byte_data_received = '0;
      test_reset();
      test_ramp();
      test_ramp_off();
      test_step();
      test_back_to_back();
      test_errors();
      test_watchdog();
      test_all_off_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
